// File: rtl/fifo_pkg.sv
// Shared state encoding and default widths for the MAC FIFO frame reader.
package fifo_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int FIFO_DEPTH   = 12;
  localparam int LENGTH_WIDTH = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DONE   = 3'd3,
    ABORT  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_read_skid.sv
// Two-entry skid buffer between the FIFO read port and the TX stream.
// Carries first/last flags with each word; flush empties it in one cycle.
module fifo_read_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_first,
  input  logic                  push_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] data0_r, data1_r;
  logic                  first0_r, first1_r, last0_r, last1_r;
  logic [1:0]            count_r;
  logic                  pop_s;

  assign pop_s = (count_r != 2'd0) & out_ready;

  // Slot 0 is always the head; slot 1 shifts down when the head is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data0_r  <= {DATA_WIDTH{1'b0}};
      data1_r  <= {DATA_WIDTH{1'b0}};
      first0_r <= 1'b0;
      first1_r <= 1'b0;
      last0_r  <= 1'b0;
      last1_r  <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            data0_r  <= push_data;
            first0_r <= push_first;
            last0_r  <= push_last;
            count_r  <= 2'd1;
          end else if (count_r == 2'd1) begin
            data1_r  <= push_data;
            first1_r <= push_first;
            last1_r  <= push_last;
            count_r  <= 2'd2;
          end else begin
            count_r <= count_r;
          end
        end
        2'b01: begin
          data0_r  <= data1_r;
          first0_r <= first1_r;
          last0_r  <= last1_r;
          count_r  <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            data0_r  <= push_data;
            first0_r <= push_first;
            last0_r  <= push_last;
          end else begin
            data0_r  <= data1_r;
            first0_r <= first1_r;
            last0_r  <= last1_r;
            data1_r  <= push_data;
            first1_r <= push_first;
            last1_r  <= push_last;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign out_valid = (count_r != 2'd0);
  assign out_data  = data0_r;
  assign out_first = first0_r;
  assign out_last  = last0_r;
  assign occupancy = count_r;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains whole frames from the MAC FIFO read port onto the TX byte stream.
// Collision retry / abort support is built when FIFO_FRAME_READER_RETRY_EN is defined.
module fifo_frame_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH   = fifo_pkg::FIFO_DEPTH,
  parameter int LENGTH_WIDTH = fifo_pkg::LENGTH_WIDTH,
  parameter int MAX_RETRIES  = 15
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             frame_valid,
  output logic                             frame_ready,
  input  logic [FIFO_DEPTH-1:0]            frame_start_address,
  input  logic [LENGTH_WIDTH-1:0]          frame_length,
  output logic                             fifo_read_enable,
  output logic                             fifo_read_reset,
  output logic [FIFO_DEPTH-1:0]            fifo_read_reset_address,
  input  logic [DATA_WIDTH-1:0]            fifo_read_data,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             tx_first,
  output logic                             tx_last,
  input  logic                             tx_retry,
  output logic                             frame_done,
  output logic                             frame_aborted,
  output logic [FIFO_DEPTH-1:0]            release_address,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

  localparam int RC_WIDTH = $clog2(MAX_RETRIES + 1);

  state_t                  state_r, next_s;
  logic [FIFO_DEPTH-1:0]   start_r, release_r;
  logic [LENGTH_WIDTH-1:0] length_r, issued_r;
  logic                    inflight_r, first_pend_r, last_pend_r;
  logic                    frame_ready_r, read_reset_r, frame_done_r;
  logic                    accept_s, retry_s, read_enable_s, pop_s, last_beat_s;
  logic [1:0]              occupancy_s;
  logic [2:0]              credit_used_s, credit_avail_s;
  logic                    skid_valid_s, skid_first_s, skid_last_s;
  logic [DATA_WIDTH-1:0]   skid_data_s;

  assign accept_s    = frame_valid & frame_ready_r;
  assign pop_s       = skid_valid_s & tx_ready;
  assign last_beat_s = (state_r == STREAM) & pop_s & skid_last_s;

  // A beat leaving this cycle frees a slot, so reads keep one word per cycle.
  assign credit_used_s  = {1'b0, occupancy_s} + {2'b00, inflight_r};
  assign credit_avail_s = 3'd2 + {2'b00, pop_s};
  assign read_enable_s  = (state_r == STREAM) & ~retry_s & (issued_r < length_r)
                        & (credit_used_s < credit_avail_s);

`ifdef FIFO_FRAME_READER_RETRY_EN
  localparam logic [RC_WIDTH-1:0] RETRY_LIMIT = RC_WIDTH'(MAX_RETRIES);

  logic [RC_WIDTH-1:0] retry_count_r;
  logic                frame_aborted_r;

  assign retry_s = tx_retry & (state_r == STREAM);

  // Retry counter: cleared per descriptor, bumped on each rewind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retry_count_r <= {RC_WIDTH{1'b0}};
    end else if (accept_s) begin
      retry_count_r <= {RC_WIDTH{1'b0}};
    end else if (retry_s && (retry_count_r < RETRY_LIMIT)) begin
      retry_count_r <= retry_count_r + RC_WIDTH'(1'b1);
    end else begin
      retry_count_r <= retry_count_r;
    end
  end

  // Abort pulse register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_aborted_r <= 1'b0;
    end else begin
      frame_aborted_r <= (next_s == ABORT);
    end
  end

  assign retry_count   = retry_count_r;
  assign frame_aborted = frame_aborted_r;
`else
  logic unused_retry_s;

  assign unused_retry_s = tx_retry;
  assign retry_s        = 1'b0;
  assign retry_count    = {RC_WIDTH{1'b0}};
  assign frame_aborted  = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_s = (frame_length == {LENGTH_WIDTH{1'b0}}) ? DONE : LOAD;
        end else begin
          next_s = IDLE;
        end
      end
      LOAD: next_s = STREAM;
      STREAM: begin
`ifdef FIFO_FRAME_READER_RETRY_EN
        if (retry_s) begin
          next_s = (retry_count_r < RETRY_LIMIT) ? LOAD : ABORT;
        end else if (last_beat_s) begin
          next_s = DONE;
        end else begin
          next_s = STREAM;
        end
`else
        if (last_beat_s) begin
          next_s = DONE;
        end else begin
          next_s = STREAM;
        end
`endif
      end
      DONE: next_s = IDLE;
`ifdef FIFO_FRAME_READER_RETRY_EN
      ABORT: next_s = IDLE;
`endif
      default: next_s = IDLE;
    endcase
  end

  // State and registered control outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      frame_ready_r <= 1'b0;
      read_reset_r  <= 1'b0;
      frame_done_r  <= 1'b0;
    end else begin
      state_r       <= next_s;
      frame_ready_r <= (next_s == IDLE);
      read_reset_r  <= (next_s == LOAD);
      frame_done_r  <= (next_s == DONE);
    end
  end

  // Descriptor latch, read issue counter and in-flight read tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_r      <= {FIFO_DEPTH{1'b0}};
      release_r    <= {FIFO_DEPTH{1'b0}};
      length_r     <= {LENGTH_WIDTH{1'b0}};
      issued_r     <= {LENGTH_WIDTH{1'b0}};
      inflight_r   <= 1'b0;
      first_pend_r <= 1'b0;
      last_pend_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        start_r   <= frame_start_address;
        length_r  <= frame_length;
        release_r <= frame_start_address + FIFO_DEPTH'(frame_length);
      end else begin
        start_r   <= start_r;
        length_r  <= length_r;
        release_r <= release_r;
      end
      if (state_r == LOAD) begin
        issued_r <= {LENGTH_WIDTH{1'b0}};
      end else if (read_enable_s) begin
        issued_r <= issued_r + LENGTH_WIDTH'(1'b1);
      end else begin
        issued_r <= issued_r;
      end
      inflight_r <= read_enable_s;
      if (read_enable_s) begin
        first_pend_r <= (issued_r == {LENGTH_WIDTH{1'b0}});
        last_pend_r  <= (issued_r == (length_r - LENGTH_WIDTH'(1'b1)));
      end else begin
        first_pend_r <= first_pend_r;
        last_pend_r  <= last_pend_r;
      end
    end
  end

  fifo_read_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (retry_s),
    .push       (inflight_r),
    .push_data  (fifo_read_data),
    .push_first (first_pend_r),
    .push_last  (last_pend_r),
    .out_valid  (skid_valid_s),
    .out_ready  (tx_ready),
    .out_data   (skid_data_s),
    .out_first  (skid_first_s),
    .out_last   (skid_last_s),
    .occupancy  (occupancy_s)
  );

  assign frame_ready             = frame_ready_r;
  assign fifo_read_enable        = read_enable_s;
  assign fifo_read_reset         = read_reset_r;
  assign fifo_read_reset_address = start_r;
  assign tx_data                 = skid_data_s;
  assign tx_valid                = skid_valid_s;
  assign tx_first                = skid_first_s;
  assign tx_last                 = skid_last_s;
  assign frame_done              = frame_done_r;
  assign release_address         = release_r;

endmodule
